fb_sdram_arbiter: RTL and testbench
===================================

FB_SDRAM_ARBITER -- requirements
Module: fb_sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, word address width of SDRAM controller port.
REQ-002 SHALL have parameter DATA_W, default 16, data width; byteenable width = DATA_W/8.
REQ-003 SHALL have parameter MAX_PEND, default 8, outstanding-read tag FIFO depth, power of 2.
REQ-004 SHALL have parameter STARVE_LIMIT, default 16, cycles p1 may wait before priority flips.
REQ-005 SHALL have port clk  in  1  sole clock; one clock; all logic rising-edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports p0_address/p0_writedata/p0_byteenable  in  ADDR_W/DATA_W/DATA_W/8  display (VGA pixel fetch) requester command.
REQ-008 SHALL have ports p0_read, p0_write  in  1 each  p0 request strobes.
REQ-009 SHALL have ports p0_waitrequest, p0_readdatavalid  out  1 each; p0_readdata  out  DATA_W.
REQ-010 SHALL have ports p1_* identical to REQ-007..009, renderer requester.
REQ-011 SHALL have ports mem_address/mem_writedata/mem_byteenable/mem_read/mem_write  out, to SDRAM controller.
REQ-012 SHALL have ports mem_waitrequest, mem_readdatavalid  in  1 each; mem_readdata  in  DATA_W.
REQ-013 SHALL have ports pend_count  out  log2(MAX_PEND)+1  reads in flight; err_unexpected  out  1  sticky.

Function
REQ-014 Request of port n = pn_read | pn_write; both asserted SHALL be treated as write, read ignored.
REQ-015 Command accepted on cycle where mem_read|mem_write =1 and mem_waitrequest=0.
REQ-016 Unlocked cycle: grant p0 if requesting, unless starve_cnt >= STARVE_LIMIT and p1 requesting, then p1; else p1 if requesting; else none.
REQ-017 Granted command presented with mem_waitrequest=1 SHALL set lock; while locked grant and mem_* command SHALL stay unchanged until acceptance; lock clears on acceptance cycle.
REQ-018 mem_* outputs SHALL mux granted port's command combinationally; mem_read=mem_write=0 when no grant.
REQ-019 pn_waitrequest SHALL be 0 only on the cycle port n's command is accepted; 1 otherwise, including when idle.
REQ-020 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle p1 requests and is not accepted; clear on p1 acceptance or p1 not requesting.
REQ-021 Each accepted read SHALL push port ID into tag FIFO; each mem_readdatavalid SHALL pop head.
REQ-022 mem_readdata SHALL be broadcast to p0_readdata and p1_readdata; pn_readdatavalid = mem_readdatavalid & (head tag == n), zero added latency, in issue order.
REQ-023 FIFO full (pend_count == MAX_PEND): read from granted port SHALL not be issued (mem_read=0, waitrequest=1) even if pop same cycle; writes SHALL proceed.
REQ-024 Full-blocked read with lock clear SHALL not block the other port's write: arbitration skips ineligible requests.
REQ-025 Simultaneous push and pop when not full: pend_count unchanged, order preserved.
REQ-026 mem_readdatavalid with FIFO empty SHALL be dropped (no pn_readdatavalid) and set err_unexpected.
REQ-027 pend_count SHALL equal pushes minus pops since reset; pointers wrap modulo MAX_PEND.

Reset
REQ-028 reset=1 at clock edge SHALL clear FIFO, pend_count=0, lock=0, starve_cnt=0, err_unexpected=0.
REQ-029 During reset: mem_read=mem_write=0, p0/p1_waitrequest=1, p0/p1_readdatavalid=0.
REQ-030 Reset mid-transfer SHALL abandon in-flight reads; late mem_readdatavalid after reset SHALL set err_unexpected (controller is reset together).

Verification
REQ-031 p0 read 0x100 and p1 write 0x200 same cycle, mem_waitrequest=0 -> p0 accepted cycle 0, p1 cycle 1; pend_count=1.
REQ-032 p0 reads continuously, p1 write pending -> p1 accepted within STARVE_LIMIT+1 cycles; starve_cnt returns 0.
REQ-033 mem_waitrequest=1 for 3 cycles on p1 write, p0 raises read meanwhile -> mem_* holds p1 command all 3 cycles; p1 accepted cycle 4, p0 after.
REQ-034 Issue 8 reads alternating p0/p1, no readdatavalid -> 9th read blocked, pend_count=8; p1 write still accepted; returns D0..D7 routed p0,p1,p0,... in order.
REQ-035 mem_readdatavalid with pend_count=0 -> no pn_readdatavalid, err_unexpected=1 until reset.
REQ-036 reset asserted with 3 reads pending -> next cycle pend_count=0, waitrequests=1, mem_read=0.

Source files
------------

// File: rtl/fb_sdram_arbiter.sv
// Two-port SDRAM arbiter: display (p0) and renderer (p1) share one controller port.
// Read returns are routed back through an in-order tag FIFO of issuing port IDs.
module fb_sdram_arbiter #(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 16,
  parameter int MAX_PEND     = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic [ADDR_W-1:0]            p0_address,
  input  logic [DATA_W-1:0]            p0_writedata,
  input  logic [DATA_W/8-1:0]          p0_byteenable,
  input  logic                         p0_read,
  input  logic                         p0_write,
  output logic                         p0_waitrequest,
  output logic                         p0_readdatavalid,
  output logic [DATA_W-1:0]            p0_readdata,

  input  logic [ADDR_W-1:0]            p1_address,
  input  logic [DATA_W-1:0]            p1_writedata,
  input  logic [DATA_W/8-1:0]          p1_byteenable,
  input  logic                         p1_read,
  input  logic                         p1_write,
  output logic                         p1_waitrequest,
  output logic                         p1_readdatavalid,
  output logic [DATA_W-1:0]            p1_readdata,

  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W-1:0]            mem_writedata,
  output logic [DATA_W/8-1:0]          mem_byteenable,
  output logic                         mem_read,
  output logic                         mem_write,
  input  logic                         mem_waitrequest,
  input  logic                         mem_readdatavalid,
  input  logic [DATA_W-1:0]            mem_readdata,

  output logic [$clog2(MAX_PEND):0]    pend_count,
  output logic                         err_unexpected
);

  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {ST_FREE, ST_LOCKED} state_e;

  state_e             state_q;
  logic               lockGnt_q;
  logic [STV_W-1:0]   starveCnt_q, starveCnt_d;
  logic [MAX_PEND-1:0] tagMem_q;
  logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]   pendCnt_q, pendCnt_d;
  logic               err_q;

  logic req0, req1, rd0, rd1, elig0, elig1;
  logic full, empty, starved;
  logic gntValid, gntSel, selRead, selWrite;
  logic cmdValid, accept, push, pop, headTag;

  // A write wins over a simultaneous read strobe; reads are ineligible while the tag FIFO is full.
  assign req0    = p0_read | p0_write;
  assign req1    = p1_read | p1_write;
  assign rd0     = p0_read & ~p0_write;
  assign rd1     = p1_read & ~p1_write;
  assign full    = (pendCnt_q == CNT_W'(MAX_PEND));
  assign empty   = (pendCnt_q == '0);
  assign elig0   = req0 & (p0_write | ~full);
  assign elig1   = req1 & (p1_write | ~full);
  assign starved = (starveCnt_q >= STV_W'(STARVE_LIMIT));

  always_comb begin
    gntValid = 1'b0;
    gntSel   = 1'b0;
    if (state_q == ST_LOCKED) begin
      gntValid = 1'b1;
      gntSel   = lockGnt_q;
    end else if (elig0 && !(starved && elig1)) begin
      gntValid = 1'b1;
      gntSel   = 1'b0;
    end else if (elig1) begin
      gntValid = 1'b1;
      gntSel   = 1'b1;
    end
  end

  assign selRead        = gntSel ? rd1 : rd0;
  assign selWrite       = gntSel ? p1_write : p0_write;
  assign mem_read       = ~reset & gntValid & selRead & ~full;
  assign mem_write      = ~reset & gntValid & selWrite;
  assign mem_address    = gntSel ? p1_address    : p0_address;
  assign mem_writedata  = gntSel ? p1_writedata  : p0_writedata;
  assign mem_byteenable = gntSel ? p1_byteenable : p0_byteenable;

  assign cmdValid       = mem_read | mem_write;
  assign accept         = cmdValid & ~mem_waitrequest;
  assign p0_waitrequest = ~(accept & ~gntSel);
  assign p1_waitrequest = ~(accept & gntSel);

  assign push             = accept & mem_read;
  assign headTag          = tagMem_q[rdPtr_q];
  assign pop              = ~reset & mem_readdatavalid & ~empty;
  assign p0_readdatavalid = pop & ~headTag;
  assign p1_readdatavalid = pop & headTag;
  assign p0_readdata      = mem_readdata;
  assign p1_readdata      = mem_readdata;

  assign pendCnt_d   = pendCnt_q + CNT_W'(push) - CNT_W'(pop);
  assign starveCnt_d = (req1 && !(accept && gntSel)) ?
                       (starved ? starveCnt_q : starveCnt_q + STV_W'(1)) : '0;

  // Lock holds the grant while the controller stalls; a dropped request releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FREE;
      lockGnt_q   <= 1'b0;
      starveCnt_q <= '0;
      tagMem_q    <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      pendCnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_FREE: begin
          if (cmdValid && mem_waitrequest) begin
            state_q   <= ST_LOCKED;
            lockGnt_q <= gntSel;
          end
        end
        ST_LOCKED: begin
          if (accept || !cmdValid) state_q <= ST_FREE;
        end
        default: state_q <= ST_FREE;
      endcase

      starveCnt_q <= starveCnt_d;
      pendCnt_q   <= pendCnt_d;

      if (push) begin
        tagMem_q[wrPtr_q] <= gntSel;
        wrPtr_q           <= wrPtr_q + PTR_W'(1);
      end
      if (pop) rdPtr_q <= rdPtr_q + PTR_W'(1);

      if (mem_readdatavalid && empty) err_q <= 1'b1;
    end
  end

  assign pend_count     = pendCnt_q;
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_fb_sdram_arbiter.sv
// Directed bench for fb_sdram_arbiter: a cycle table for arbitration/lock/FIFO routing,
// plus hand sequences for starvation, FIFO-full, unexpected returns and reset.
module tb_fb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] p0_address, p1_address, mem_address;
  logic [15:0] p0_writedata, p1_writedata, mem_writedata;
  logic [1:0]  p0_byteenable, p1_byteenable, mem_byteenable;
  logic        p0_read, p0_write, p0_waitrequest, p0_readdatavalid;
  logic        p1_read, p1_write, p1_waitrequest, p1_readdatavalid;
  logic [15:0] p0_readdata, p1_readdata, mem_readdata;
  logic        mem_read, mem_write, mem_waitrequest, mem_readdatavalid;
  logic [3:0]  pend_count;
  logic        err_unexpected;

  int total = 0;
  int bad   = 0;

  fb_sdram_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_address(p0_address), .p0_writedata(p0_writedata), .p0_byteenable(p0_byteenable),
    .p0_read(p0_read), .p0_write(p0_write), .p0_waitrequest(p0_waitrequest),
    .p0_readdatavalid(p0_readdatavalid), .p0_readdata(p0_readdata),
    .p1_address(p1_address), .p1_writedata(p1_writedata), .p1_byteenable(p1_byteenable),
    .p1_read(p1_read), .p1_write(p1_write), .p1_waitrequest(p1_waitrequest),
    .p1_readdatavalid(p1_readdatavalid), .p1_readdata(p1_readdata),
    .mem_address(mem_address), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_read(mem_read), .mem_write(mem_write), .mem_waitrequest(mem_waitrequest),
    .mem_readdatavalid(mem_readdatavalid), .mem_readdata(mem_readdata),
    .pend_count(pend_count), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        p0r, p0w, p1r, p1w, mwait, rdv;
    logic [15:0] rdata;
    logic        eRd, eWr;
    logic [24:0] eAddr;
    logic        eP0w, eP1w, eP0v, eP1v;
    logic [3:0]  ePend;
  } vec_t;

  vec_t vecs[16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic p0r, input logic p0w, input logic p1r, input logic p1w,
                               input logic mwait, input logic rdv, input logic [15:0] rdata);
    p0_read = p0r; p0_write = p0w; p1_read = p1r; p1_write = p1w;
    mem_waitrequest = mwait; mem_readdatavalid = rdv; mem_readdata = rdata;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int mp;
    reset = 1'b1;
    p0_address = 25'h100; p1_address = 25'h200;
    p0_writedata = 16'hC0DE; p1_writedata = 16'hBEEF;
    p0_byteenable = 2'b11; p1_byteenable = 2'b01;
    applyStimulus(1, 0, 1, 0, 0, 1, 16'h0);

    //            p0r p0w p1r p1w wt rdv rdata     eRd eWr eAddr     p0w p1w p0v p1v pend
    vecs[0]  = '{1, 0, 0, 1, 0, 0, 16'h0,     1, 0, 25'h100, 0, 1, 0, 0, 4'd0};
    vecs[1]  = '{0, 0, 0, 1, 0, 0, 16'h0,     0, 1, 25'h200, 1, 0, 0, 0, 4'd1};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 16'h0,     0, 0, 25'h0,   1, 1, 0, 0, 4'd1};
    vecs[3]  = '{0, 0, 0, 1, 1, 0, 16'h0,     0, 1, 25'h200, 1, 1, 0, 0, 4'd1};
    vecs[4]  = '{1, 0, 0, 1, 1, 0, 16'h0,     0, 1, 25'h200, 1, 1, 0, 0, 4'd1};
    vecs[5]  = '{1, 0, 0, 1, 1, 0, 16'h0,     0, 1, 25'h200, 1, 1, 0, 0, 4'd1};
    vecs[6]  = '{1, 0, 0, 1, 0, 0, 16'h0,     0, 1, 25'h200, 1, 0, 0, 0, 4'd1};
    vecs[7]  = '{1, 0, 0, 0, 0, 0, 16'h0,     1, 0, 25'h100, 0, 1, 0, 0, 4'd1};
    vecs[8]  = '{0, 0, 0, 0, 0, 1, 16'hAAAA,  0, 0, 25'h0,   1, 1, 1, 0, 4'd2};
    vecs[9]  = '{0, 0, 0, 0, 0, 1, 16'h5555,  0, 0, 25'h0,   1, 1, 1, 0, 4'd1};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 16'h0,     0, 0, 25'h0,   1, 1, 0, 0, 4'd0};
    vecs[11] = '{1, 1, 0, 0, 0, 0, 16'h0,     0, 1, 25'h100, 0, 1, 0, 0, 4'd0};
    vecs[12] = '{0, 0, 1, 0, 0, 0, 16'h0,     1, 0, 25'h200, 1, 0, 0, 0, 4'd0};
    vecs[13] = '{1, 0, 0, 0, 0, 1, 16'h1234,  1, 0, 25'h100, 0, 1, 0, 1, 4'd1};
    vecs[14] = '{0, 0, 0, 0, 0, 1, 16'h4321,  0, 0, 25'h0,   1, 1, 1, 0, 4'd1};
    vecs[15] = '{0, 0, 0, 0, 0, 0, 16'h0,     0, 0, 25'h0,   1, 1, 0, 0, 4'd0};

    // Outputs are forced quiet while reset is held, even with requests and returns present.
    @(posedge clk); @(negedge clk); #2;
    checkOutput("rst_mem_read", mem_read, 0);
    checkOutput("rst_p0_wait", p0_waitrequest, 1);
    checkOutput("rst_p1_wait", p1_waitrequest, 1);
    checkOutput("rst_p0_rdv", p0_readdatavalid, 0);
    checkOutput("rst_p1_rdv", p1_readdatavalid, 0);
    checkOutput("rst_pend", pend_count, 0);
    checkOutput("rst_err", err_unexpected, 0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].p0r, vecs[i].p0w, vecs[i].p1r, vecs[i].p1w,
                    vecs[i].mwait, vecs[i].rdv, vecs[i].rdata);
      #2;
      checkOutput($sformatf("v%0d_mem_read", i), mem_read, vecs[i].eRd);
      checkOutput($sformatf("v%0d_mem_write", i), mem_write, vecs[i].eWr);
      if (vecs[i].eRd || vecs[i].eWr)
        checkOutput($sformatf("v%0d_mem_address", i), mem_address, vecs[i].eAddr);
      checkOutput($sformatf("v%0d_p0_wait", i), p0_waitrequest, vecs[i].eP0w);
      checkOutput($sformatf("v%0d_p1_wait", i), p1_waitrequest, vecs[i].eP1w);
      checkOutput($sformatf("v%0d_p0_rdv", i), p0_readdatavalid, vecs[i].eP0v);
      checkOutput($sformatf("v%0d_p1_rdv", i), p1_readdatavalid, vecs[i].eP1v);
      checkOutput($sformatf("v%0d_pend", i), pend_count, vecs[i].ePend);
      if (vecs[i].rdv) begin
        checkOutput($sformatf("v%0d_p0_data", i), p0_readdata, vecs[i].rdata);
        checkOutput($sformatf("v%0d_p1_data", i), p1_readdata, vecs[i].rdata);
      end
    end

    // Starvation: p0 streams reads, p1 holds a write; p1 must win on cycle 16.
    mp = 0;
    for (int k = 0; k < 17; k++) begin
      logic rdvNow;
      rdvNow = (mp > 0);
      @(negedge clk);
      applyStimulus(1, 0, 0, 1, 0, rdvNow, 16'h0);
      #2;
      checkOutput($sformatf("stv%0d_p0_wait", k), p0_waitrequest, (k == 16));
      checkOutput($sformatf("stv%0d_p1_wait", k), p1_waitrequest, (k != 16));
      mp = mp + ((k != 16) ? 1 : 0) - (rdvNow ? 1 : 0);
    end
    @(negedge clk);
    applyStimulus(1, 0, 0, 1, 0, 0, 16'h0);
    #2;
    checkOutput("stv_after_p0_wait", p0_waitrequest, 0);
    checkOutput("stv_after_p1_wait", p1_waitrequest, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 1, 16'h7777);
    #2;
    checkOutput("stv_drain_p0_rdv", p0_readdatavalid, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0);
    #2;
    checkOutput("stv_pend", pend_count, 0);

    // Fill the tag FIFO with alternating reads, then check blocking and in-order routing.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus((i % 2) == 0, 0, (i % 2) == 1, 0, 0, 0, 16'h0);
      #2;
      checkOutput($sformatf("fill%0d_pend", i), pend_count, i);
      checkOutput($sformatf("fill%0d_mem_read", i), mem_read, 1);
    end
    @(negedge clk);
    applyStimulus(1, 0, 0, 1, 0, 0, 16'h0);
    #2;
    checkOutput("full_mem_read", mem_read, 0);
    checkOutput("full_mem_write", mem_write, 1);
    checkOutput("full_p0_wait", p0_waitrequest, 1);
    checkOutput("full_p1_wait", p1_waitrequest, 0);
    checkOutput("full_pend", pend_count, 8);
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0, 1, 16'hD000);
    #2;
    checkOutput("full_pop_mem_read", mem_read, 0);
    checkOutput("full_pop_p0_wait", p0_waitrequest, 1);
    checkOutput("ret0_p0_rdv", p0_readdatavalid, 1);
    checkOutput("ret0_p1_rdv", p1_readdatavalid, 0);
    checkOutput("ret0_data", p0_readdata, 16'hD000);
    checkOutput("ret0_pend", pend_count, 8);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 1, 16'hD000 + 16'(i));
      #2;
      checkOutput($sformatf("ret%0d_p0_rdv", i), p0_readdatavalid, (i % 2) == 0);
      checkOutput($sformatf("ret%0d_p1_rdv", i), p1_readdatavalid, (i % 2) == 1);
      checkOutput($sformatf("ret%0d_data", i), p1_readdata, 16'hD000 + 16'(i));
      checkOutput($sformatf("ret%0d_pend", i), pend_count, 8 - i);
    end

    // A return with nothing outstanding is dropped and flagged until reset.
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 1, 16'hBAD0);
    #2;
    checkOutput("unexp_pend", pend_count, 0);
    checkOutput("unexp_err_before", err_unexpected, 0);
    checkOutput("unexp_p0_rdv", p0_readdatavalid, 0);
    checkOutput("unexp_p1_rdv", p1_readdatavalid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 16'h0);
      #2;
      checkOutput($sformatf("unexp_err_sticky%0d", i), err_unexpected, 1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2;
    checkOutput("unexp_err_cleared", err_unexpected, 0);

    // Reset with three reads outstanding abandons them; a late return is then unexpected.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1, 0, 0, 0, 0, 0, 16'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    #2;
    checkOutput("midrst_mem_read", mem_read, 0);
    checkOutput("midrst_p0_wait", p0_waitrequest, 1);
    checkOutput("midrst_p1_wait", p1_waitrequest, 1);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0);
    #2;
    checkOutput("midrst_pend", pend_count, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 1, 16'hEEEE);
    #2;
    checkOutput("late_p0_rdv", p0_readdatavalid, 0);
    checkOutput("late_p1_rdv", p1_readdatavalid, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 16'h0);
    #2;
    checkOutput("late_err", err_unexpected, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
